// File: rtl/shift_pkg.sv
// Shared definitions for the multicycle shifter.
// Holds the op and amount-select encodings, the controller state type
// and a helper that tells real shift ops apart from NOP-like codes.
package shift_pkg;

  // Operation encodings; codes 101-111 behave as NOP
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Shift-amount source encodings
  localparam logic [1:0] AMT_REGB = 2'b00;
  localparam logic [1:0] AMT_IMM  = 2'b01;
  localparam logic [1:0] AMT_MEM  = 2'b10;
  localparam logic [1:0] AMT_ZERO = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // True only for ops that actually move bits
  function automatic logic isShiftOp(input logic [2:0] opCode);
    return (opCode == OP_SLL) || (opCode == OP_SRL) ||
           (opCode == OP_SRA) || (opCode == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_amt_select.sv
// Shift-amount source selector (purely combinational).
// Ports:
//   i_amtSel  - 00 reg B, 01 immediate shamt field, 10 memory data, 11 zero
//   i_regB    - register B contents
//   i_imm     - 16-bit instruction immediate; shamt sits at [AMT_W+5:6]
//   i_memOut  - memory data output
//   o_amount  - selected shift amount, AMT_W bits
module shift_amt_select
  import shift_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AMT_W  = $clog2(DATA_W)
) (
  input  logic [1:0]        i_amtSel,
  input  logic [DATA_W-1:0] i_regB,
  input  logic [15:0]       i_imm,
  input  logic [DATA_W-1:0] i_memOut,
  output logic [AMT_W-1:0]  o_amount
);

  // Only the low bits of each source matter; the rest are folded away here
  logic w_unused;
  assign w_unused = ^{i_regB, i_imm, i_memOut};

  // Every select code produces a defined amount, including the zero case
  always_comb begin
    o_amount = '0;
    case (i_amtSel)
      AMT_REGB: o_amount = i_regB[AMT_W-1:0];
      AMT_IMM:  o_amount = i_imm[AMT_W+5:6];
      AMT_MEM:  o_amount = i_memOut[AMT_W-1:0];
      default:  o_amount = '0;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Multicycle shifter with a start/busy/done handshake.
// An accepted start latches the operand, the selected amount and the op;
// the operand is then shifted by up to STEP bits per cycle until the
// remaining amount reaches zero, and done pulses for one cycle.
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous, active-low reset
//   start    - request, honoured only in IDLE or DONE
//   amt_sel  - amount source select (see shift_amt_select)
//   op       - 000 NOP, 001 SLL, 010 SRL, 011 SRA, 100 ROR, others NOP
//   data_in  - operand
//   reg_b    - register B contents
//   imm      - instruction immediate
//   mem_out  - memory data output
//   result   - shifted value, stable from DONE until the next accepted start
//   busy     - high while shifting
//   done     - one-cycle completion pulse
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AMT_W  = $clog2(DATA_W),
  parameter int STEP   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        amt_sel,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] reg_b,
  input  logic [15:0]       imm,
  input  logic [DATA_W-1:0] mem_out,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              done
);

  // One extra bit so a step count equal to DATA_W still fits
  localparam int NW = AMT_W + 1;

  state_e            r_state;
  state_e            w_nextState;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] w_stepResult;
  logic [AMT_W-1:0]  r_remaining;
  logic [AMT_W-1:0]  w_remainingNext;
  logic [AMT_W-1:0]  w_amount;
  logic [2:0]        r_op;
  logic              w_accept;
  logic [NW-1:0]     w_n;
  logic [NW-1:0]     w_rotLeft;

  shift_amt_select #(
    .DATA_W (DATA_W),
    .AMT_W  (AMT_W)
  ) u_amtSelect (
    .i_amtSel (amt_sel),
    .i_regB   (reg_b),
    .i_imm    (imm),
    .i_memOut (mem_out),
    .o_amount (w_amount)
  );

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

  // Bits moved this cycle: the full STEP, or whatever is left if smaller.
  // When the full STEP is taken, remaining >= STEP, so STEP < DATA_W and the
  // truncation to AMT_W bits below is exact.
  always_comb begin
    w_n = NW'(STEP);
    if (int'(r_remaining) < STEP) begin
      w_n = {1'b0, r_remaining};
    end
  end

  assign w_remainingNext = r_remaining - w_n[AMT_W-1:0];
  assign w_rotLeft       = NW'(DATA_W) - w_n;

  // Single step-shift network shared by all ops. Arithmetic right shift keeps
  // the MSB unchanged, so the sign captured at accept is carried through
  // every step without a separate sign register.
  always_comb begin
    w_stepResult = r_result;
    case (r_op)
      OP_SLL:  w_stepResult = r_result << w_n;
      OP_SRL:  w_stepResult = r_result >> w_n;
      OP_SRA:  w_stepResult = $signed(r_result) >>> w_n;
      OP_ROR:  w_stepResult = (r_result >> w_n) | (r_result << w_rotLeft);
      default: w_stepResult = r_result;
    endcase
  end

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: zero amounts and NOP-like ops skip straight to DONE,
  // and DONE can accept a new request directly for back-to-back operation
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          if ((w_amount == '0) || !isShiftOp(op)) begin
            w_nextState = DONE;
          end else begin
            w_nextState = SHIFT;
          end
        end else begin
          w_nextState = IDLE;
        end
      end
      SHIFT: begin
        if (w_remainingNext == '0) begin
          w_nextState = DONE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy   = (r_state == SHIFT);
    done   = (r_state == DONE);
    result = r_result;
  end

  // Datapath: latch on accept, step while shifting, otherwise hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result    <= '0;
      r_remaining <= '0;
      r_op        <= OP_NOP;
    end else if (w_accept) begin
      r_result    <= data_in;
      r_remaining <= w_amount;
      r_op        <= op;
    end else if (r_state == SHIFT) begin
      r_result    <= w_stepResult;
      r_remaining <= w_remainingNext;
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Testbench for shift_unit_seq with a queue-based scoreboard.
// Two instances share the data inputs: uA shifts 1 bit per cycle, uB 4 bits.
// Stimulus pushes the expected result and done cycle; a monitor pops and
// compares whenever an instance raises done.
module tb_shift_unit_seq;
  import shift_pkg::*;

  typedef struct {
    logic [31:0] result;
    int          doneCycle;
    string       name;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        startA;
  logic        startB;
  logic [1:0]  amtSel;
  logic [2:0]  opCode;
  logic [31:0] dataIn;
  logic [31:0] regB;
  logic [15:0] imm;
  logic [31:0] memOut;
  logic [31:0] resultA;
  logic [31:0] resultB;
  logic        busyA;
  logic        busyB;
  logic        doneA;
  logic        doneB;

  int   cycleCnt  = 0;
  int   testCount = 0;
  int   failCount = 0;
  exp_t qA[$];
  exp_t qB[$];
  exp_t eA;
  exp_t eB;

  shift_unit_seq #(.DATA_W(32), .STEP(1)) uA (
    .clk     (clk),
    .reset   (reset),
    .start   (startA),
    .amt_sel (amtSel),
    .op      (opCode),
    .data_in (dataIn),
    .reg_b   (regB),
    .imm     (imm),
    .mem_out (memOut),
    .result  (resultA),
    .busy    (busyA),
    .done    (doneA)
  );

  shift_unit_seq #(.DATA_W(32), .STEP(4)) uB (
    .clk     (clk),
    .reset   (reset),
    .start   (startB),
    .amt_sel (amtSel),
    .op      (opCode),
    .data_in (dataIn),
    .reg_b   (regB),
    .imm     (imm),
    .mem_out (memOut),
    .result  (resultB),
    .busy    (busyB),
    .done    (doneB)
  );

  // Free-running clock with a 10-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index used to time-stamp expected done pulses
  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
  end

  // Single comparison, counted and reported on mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    testCount++;
    if (actual !== required) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
    end
  endtask

  // Drives one request just after a negedge, records the expectation when
  // the request should be accepted, and drops start after one cycle
  task automatic applyStimulus(input bit toB, input string name,
                               input logic [1:0] sel, input logic [2:0] opc,
                               input logic [31:0] din, input logic [31:0] rb,
                               input logic [15:0] im, input logic [31:0] mo,
                               input bit expectDone, input logic [31:0] expRes,
                               input int latency);
    exp_t e;
    amtSel = sel;
    opCode = opc;
    dataIn = din;
    regB   = rb;
    imm    = im;
    memOut = mo;
    if (toB) startB = 1'b1;
    else     startA = 1'b1;
    if (expectDone) begin
      e.result    = expRes;
      e.doneCycle = cycleCnt + latency;
      e.name      = name;
      if (toB) qB.push_back(e);
      else     qA.push_back(e);
    end
    @(negedge clk);
    startA = 1'b0;
    startB = 1'b0;
  endtask

  // SLL by imm shamt 5 on the 1-bit instance, with busy window checks
  task automatic runScenario1(input string tag);
    applyStimulus(0, {tag, " sll5"}, AMT_IMM, OP_SLL, 32'h0000_0001, 32'h0,
                  16'h0140, 32'h0, 1, 32'h0000_0020, 6);
    checkOutput({tag, " busy first"}, 32'(busyA), 32'h1);
    repeat (4) @(negedge clk);
    checkOutput({tag, " busy last"}, 32'(busyA), 32'h1);
    @(negedge clk);
    checkOutput({tag, " busy in done"}, 32'(busyA), 32'h0);
    @(negedge clk);
    checkOutput({tag, " done after"}, 32'(doneA), 32'h0);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (doneA) begin
      if (qA.size() == 0) begin
        testCount++;
        failCount++;
        $display("[TB] FAIL unexpected doneA: got done at cycle %0d, expected none", cycleCnt);
      end else begin
        eA = qA.pop_front();
        checkOutput({eA.name, " result"}, resultA, eA.result);
        checkOutput({eA.name, " done cycle"}, 32'(cycleCnt), 32'(eA.doneCycle));
      end
    end
    if (doneB) begin
      if (qB.size() == 0) begin
        testCount++;
        failCount++;
        $display("[TB] FAIL unexpected doneB: got done at cycle %0d, expected none", cycleCnt);
      end else begin
        eB = qB.pop_front();
        checkOutput({eB.name, " result"}, resultB, eB.result);
        checkOutput({eB.name, " done cycle"}, 32'(cycleCnt), 32'(eB.doneCycle));
      end
    end
  end

  // Directed sequence
  initial begin
    int waitCnt;
    reset  = 1'b0;
    startA = 1'b0;
    startB = 1'b0;
    amtSel = 2'b00;
    opCode = OP_NOP;
    dataIn = '0;
    regB   = '0;
    imm    = '0;
    memOut = '0;

    #12;
    checkOutput("reset resultA", resultA, 32'h0);
    checkOutput("reset busyA", 32'(busyA), 32'h0);
    checkOutput("reset doneA", 32'(doneA), 32'h0);
    checkOutput("reset resultB", resultB, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    runScenario1("s1");

    // 4-bit steps: SRA by 7 takes 2 shift cycles
    applyStimulus(1, "s2 sra7", AMT_REGB, OP_SRA, 32'h8000_0000, 32'hFFFF_FFE7,
                  16'h0, 32'h0, 1, 32'hFF00_0000, 3);
    repeat (4) @(negedge clk);
    applyStimulus(1, "b sll31", AMT_IMM, OP_SLL, 32'h0000_0003, 32'h0,
                  16'h07C0, 32'h0, 1, 32'h8000_0000, 9);
    repeat (10) @(negedge clk);
    applyStimulus(1, "b ror12", AMT_REGB, OP_ROR, 32'h1234_5678, 32'h0000_000C,
                  16'h0, 32'h0, 1, 32'h6781_2345, 4);
    repeat (5) @(negedge clk);
    applyStimulus(1, "b srl4", AMT_REGB, OP_SRL, 32'hF000_0000, 32'h0000_0004,
                  16'h0, 32'h0, 1, 32'h0F00_0000, 2);
    repeat (3) @(negedge clk);
    applyStimulus(1, "b nop", AMT_REGB, OP_NOP, 32'hCAFE_F00D, 32'h0000_0009,
                  16'h0, 32'h0, 1, 32'hCAFE_F00D, 1);
    repeat (2) @(negedge clk);
    applyStimulus(1, "b op7", AMT_MEM, 3'b111, 32'h0BAD_CAFE, 32'h0,
                  16'h0, 32'h0000_0005, 1, 32'h0BAD_CAFE, 1);
    repeat (2) @(negedge clk);

    // Zero amount: completes at once without ever shifting
    applyStimulus(0, "s3 zero", AMT_ZERO, OP_ROR, 32'hDEAD_BEEF, 32'h0000_0003,
                  16'h0, 32'h0, 1, 32'hDEAD_BEEF, 1);
    checkOutput("s3 busy", 32'(busyA), 32'h0);
    @(negedge clk);

    // ROR by 31, an ignored start mid-flight, then a start in the DONE cycle
    applyStimulus(0, "s4 ror31", AMT_MEM, OP_ROR, 32'h0000_0001, 32'h0,
                  16'h0, 32'h0000_001F, 1, 32'h0000_0002, 32);
    repeat (9) @(negedge clk);
    applyStimulus(0, "s4 ignored", AMT_ZERO, OP_SLL, 32'h0000_FFFF, 32'h0,
                  16'h0, 32'h0, 0, 32'h0, 0);
    checkOutput("s4 busy after ignored start", 32'(busyA), 32'h1);
    repeat (21) @(negedge clk);
    checkOutput("s4 done pulse", 32'(doneA), 32'h1);
    applyStimulus(0, "s4 b2b srl1", AMT_REGB, OP_SRL, 32'h0000_0002, 32'h0000_0001,
                  16'h0, 32'h0, 1, 32'h0000_0001, 2);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of an SRL by 8
    applyStimulus(0, "s5 killed", AMT_REGB, OP_SRL, 32'hFFFF_0000, 32'h0000_0008,
                  16'h0, 32'h0, 0, 32'h0, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("s5 reset result", resultA, 32'h0);
    checkOutput("s5 reset busy", 32'(busyA), 32'h0);
    checkOutput("s5 reset done", 32'(doneA), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    runScenario1("s5 after reset");

    // Drain: every expectation must have been consumed within a bounded wait
    waitCnt = 0;
    while (((qA.size() != 0) || (qB.size() != 0)) && (waitCnt < 100)) begin
      @(negedge clk);
      waitCnt++;
    end
    testCount++;
    if ((qA.size() != 0) || (qB.size() != 0)) begin
      failCount++;
      $display("[TB] FAIL drain: got %0d/%0d pending, expected 0/0", qA.size(), qB.size());
    end
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
